// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset PC, bubble word, fetch FSM encoding.
// No logic; constants and types only.
// Imported by the IF-stage fetch unit.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  // Word-align a byte address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches one word at a time over req/gnt/rvalid, holds it for ID.
// Latency: request, wait and full states give at least 3 cycles per instruction; outputs are registered.
// Backpressure: pc_en=0 holds the buffered word and PC; fetch_busy stalls IF/ID while nothing is buffered.
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstructionF,
  output logic [31:0] PCounter4F,
  output logic [31:0] PCounter8F,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         ibuf_valid_q, ibuf_valid_d;
  logic         kill_q, kill_d;
  logic         kill_set;
  logic         fire;
  logic         unused_redirect_lsb;

  // Hook for a future flush input: driving this while a response is pending discards it.
  assign kill_set = 1'b0;

  // Low address bits of the redirect target are forced to zero.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // IF/ID captures the current F outputs only when ID advances and a word is buffered.
  assign fire = pc_en & ibuf_valid_q;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      ibuf_q       <= 32'h0;
      ibuf_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_q       <= ibuf_d;
      ibuf_valid_q <= ibuf_valid_d;
      kill_q       <= kill_d;
    end
  end

  // Next-state: issue request, wait for data, then hold it until ID takes it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ibuf_d       = ibuf_q;
    ibuf_valid_d = ibuf_valid_q;
    kill_d       = kill_q | kill_set;
    case (state_q)
      REQ: begin
        // A response arriving here is stale (e.g. from before reset) and is ignored.
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            ibuf_d       = imem_rdata;
            ibuf_valid_d = 1'b1;
            state_d      = FULL;
          end
        end
      end
      FULL: begin
        // The word leaving on a redirect fire is the delay slot; it is delivered regardless.
        if (fire) begin
          ibuf_valid_d = 1'b0;
          pc_d         = redirect ? word_align(redirect_pc) : pc_q + 32'd4;
          state_d      = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Request is masked while reset is held so nothing is issued before release.
  assign imem_req     = reset & (state_q == REQ);
  assign imem_addr    = pc_q;
  assign InstructionF = ibuf_valid_q ? ibuf_q : NOP_WORD;
  assign PCounter4F   = pc_q + 32'd4;
  assign PCounter8F   = pc_q + 32'd8;
  assign fetch_busy   = ~ibuf_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake stalls, ID stalls, delay-slot redirect,
// mid-fetch reset with stale response, and PC wraparound.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstructionF;
  logic [31:0] PCounter4F;
  logic [31:0] PCounter8F;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstructionF(InstructionF),
    .PCounter4F  (PCounter4F),
    .PCounter8F  (PCounter8F),
    .fetch_busy  (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant immediately, return data the following cycle; ends in FULL.
  task automatic fetch(input logic [31:0] word);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic fire_seq(input logic redir, input logic [31:0] tgt);
    pc_en       = 1'b1;
    redirect    = redir;
    redirect_pc = tgt;
    step();
    pc_en    = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    pc_en       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // Held in reset
    step();
    chk("rst_req",   {31'h0, imem_req},   32'h0);
    chk("rst_instr", InstructionF,        32'h0);
    chk("rst_pc4",   PCounter4F,          32'h3004);
    chk("rst_pc8",   PCounter8F,          32'h3008);
    chk("rst_busy",  {31'h0, fetch_busy}, 32'h1);

    // Release: request appears in the first cycle
    reset = 1'b1;
    #1;
    chk("rel_req",  {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr,         32'h3000);

    // Immediate grant, data one cycle later
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req",  {31'h0, imem_req},   32'h0);
    chk("wait_busy", {31'h0, fetch_busy}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2408_0005;
    step();
    imem_rvalid = 1'b0;
    chk("f1_instr", InstructionF,        32'h2408_0005);
    chk("f1_pc4",   PCounter4F,          32'h3004);
    chk("f1_busy",  {31'h0, fetch_busy}, 32'h0);
    chk("f1_req",   {31'h0, imem_req},   32'h0);
    fire_seq(1'b0, 32'h0);
    chk("f1_next_req",   {31'h0, imem_req}, 32'h1);
    chk("f1_next_addr",  imem_addr,         32'h3004);
    chk("f1_next_instr", InstructionF,      32'h0);

    // Grant withheld for 3 cycles: request stable
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nogt_req",   {31'h0, imem_req},   32'h1);
      chk("nogt_addr",  imem_addr,           32'h3004);
      chk("nogt_busy",  {31'h0, fetch_busy}, 32'h1);
      chk("nogt_instr", InstructionF,        32'h0);
    end
    fetch(32'h1111_1111);

    // ID stall for 4 cycles; a redirect during the stall is ignored
    redirect    = 1'b1;
    redirect_pc = 32'h0000_7000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_instr", InstructionF,      32'h1111_1111);
      chk("stall_pc4",   PCounter4F,        32'h3008);
      chk("stall_pc8",   PCounter8F,        32'h300C);
      chk("stall_req",   {31'h0, imem_req}, 32'h0);
    end
    redirect = 1'b0;
    fire_seq(1'b0, 32'h0);
    chk("stall_fire_addr", imem_addr,  32'h3008);
    chk("stall_fire_pc4",  PCounter4F, 32'h300C);

    // Walk to 0x3010
    fetch(32'hAAAA_0001);
    fire_seq(1'b0, 32'h0);
    fetch(32'hAAAA_0002);
    fire_seq(1'b0, 32'h0);
    chk("walk_addr", imem_addr, 32'h3010);
    fetch(32'h1000_0002);
    chk("ds_pc4", PCounter4F, 32'h3014);

    // Redirect fire: delay slot word is what IF/ID captures on that edge
    pc_en       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3103;
    #1;
    chk("ds_instr", InstructionF, 32'h1000_0002);
    step();
    pc_en    = 1'b0;
    redirect = 1'b0;
    chk("redir_addr", imem_addr,         32'h3100);
    chk("redir_pc8",  PCounter8F,        32'h3108);
    chk("redir_req",  {31'h0, imem_req}, 32'h1);

    // Redirect while nothing buffered is ignored
    pc_en       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    step();
    pc_en    = 1'b0;
    redirect = 1'b0;
    chk("empty_redir_addr", imem_addr, 32'h3100);

    // Reset while waiting, then a stale response during REQ
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("pre_rst_req", {31'h0, imem_req}, 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_req",  {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc4",  PCounter4F,        32'h3004);
    chk("mid_rst_addr", imem_addr,         32'h3000);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("stale_instr", InstructionF,        32'h0);
    chk("stale_busy",  {31'h0, fetch_busy}, 32'h1);
    chk("stale_req",   {31'h0, imem_req},   32'h1);
    chk("stale_addr",  imem_addr,           32'h3000);
    fetch(32'h2408_0005);
    chk("refetch_instr", InstructionF, 32'h2408_0005);

    // Wraparound: redirect to top word, then advance
    fire_seq(1'b1, 32'hFFFF_FFFF);
    chk("top_addr", imem_addr,  32'hFFFF_FFFC);
    chk("top_pc4",  PCounter4F, 32'h0);
    chk("top_pc8",  PCounter8F, 32'h4);
    fetch(32'h0BAD_0000);
    fire_seq(1'b0, 32'h0);
    chk("wrap_addr", imem_addr,  32'h0);
    chk("wrap_pc4",  PCounter4F, 32'h4);
    chk("wrap_pc8",  PCounter8F, 32'h8);
    fetch(32'h1234_5678);
    chk("wrap_instr", InstructionF, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
